pc_gen_seq: RTL and testbench

//  Registered, parametrised next-PC generator for the STRV32I fetch stage; replaces the combinational PC mux.

---
 rtl/strv32i_pkg.sv | 19 +
 rtl/pc_redirect_arb.sv | 47 ++++
 rtl/pc_gen_seq.sv | 130 +++++++++++++
 tb/tb_pc_gen_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/strv32i_pkg.sv
// Shared STRV32I fetch-stage types: FSM states, redirect-source encoding and the default address width.
package strv32i_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    RS_NONE   = 2'd0,
    RS_BRANCH = 2'd1,
    RS_MRET   = 2'd2,
    RS_TRAP   = 2'd3
  } redirect_src_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: picks trap > mret > branch, sanitises the target and
// flags targets that cannot be fetched at the configured alignment.
module pc_redirect_arb
  import strv32i_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int IALIGN = 4
) (
  input  logic            trap_take_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            branch_take_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            sel_vld_o,
  output logic [XLEN-1:0] sel_target_o,
  output logic            sel_misaligned_o
);

  redirect_src_e   src;
  logic [XLEN-1:0] tgt;

  always_comb begin
    src = RS_NONE;
    tgt = '0;
    if (trap_take_i) begin
      src = RS_TRAP;
      tgt = trap_vector_i;
    end else if (mret_i) begin
      src = RS_MRET;
      tgt = epc_i;
    end else if (branch_take_i) begin
      src = RS_BRANCH;
      tgt = branch_target_i;
    end
    tgt[0] = 1'b0;
    sel_misaligned_o = 1'b0;
    // A trap vector must always be taken, so it is realigned rather than rejected.
    if (IALIGN == 4 && tgt[1]) begin
      if (src == RS_TRAP) tgt[1] = 1'b0;
      else sel_misaligned_o = (src != RS_NONE);
    end
    sel_vld_o    = (src != RS_NONE) && !sel_misaligned_o;
    sel_target_o = tgt;
  end

endmodule

// File: rtl/pc_gen_seq.sv
// Registered next-PC generator: owns the fetch PC and issues it over a valid/ready handshake.
// Handshake: a request fires when ifetch_valid_out & ifetch_ready_in; once raised, valid and iaddr_out hold until it fires.
module pc_gen_seq
  import strv32i_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter int              IALIGN    = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            stall_in,
  input  logic            branch_take_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic            trap_take_in,
  input  logic [XLEN-1:0] trap_vector_in,
  input  logic            mret_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic            ifetch_ready_in,
  output logic            ifetch_valid_out,
  output logic [XLEN-1:0] iaddr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic            misaligned_out,
  output logic [XLEN-1:0] misaligned_addr_out,
  output logic [1:0]      state_dbg_out
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            hold_q, hold_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic            valid, fire, in_wait;
  logic            sel_vld, sel_mis;
  logic [XLEN-1:0] sel_target;

  // Only a trap may replace a redirect that is already waiting for its handshake.
  assign in_wait = (state_q == S_WAIT);

  pc_redirect_arb #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_arb (
    .trap_take_i      (trap_take_in),
    .trap_vector_i    (trap_vector_in),
    .mret_i           (mret_in && !in_wait),
    .epc_i            (epc_in),
    .branch_take_i    (branch_take_in && !in_wait),
    .branch_target_i  (branch_target_in),
    .sel_vld_o        (sel_vld),
    .sel_target_o     (sel_target),
    .sel_misaligned_o (sel_mis)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_BOOT;
      pc_q       <= BOOT_ADDR;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      hold_q     <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      hold_q     <= hold_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    hold_d     = valid && !ifetch_ready_in;
    mis_d      = sel_mis;
    mis_addr_d = sel_mis ? sel_target : mis_addr_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        if (sel_vld) pc_d = sel_target;
      end
      S_RUN: begin
        if (sel_vld) begin
          // A request already on the bus must stay stable, so park the target.
          if (fire || !valid) begin
            pc_d = sel_target;
          end else begin
            pend_d     = sel_target;
            pend_vld_d = 1'b1;
            state_d    = S_WAIT;
          end
        end else if (fire && !sel_mis) begin
          pc_d = pc_q + XLEN'(IALIGN);
        end
      end
      S_WAIT: begin
        if (sel_vld) pend_d = sel_target;
        if (fire && pend_vld_q) begin
          pc_d       = sel_vld ? sel_target : pend_q;
          pend_vld_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    valid               = (state_q != S_BOOT) && (!stall_in || hold_q);
    fire                = valid && ifetch_ready_in;
    ifetch_valid_out    = valid;
    iaddr_out           = pc_q;
    pc_out              = pc_q;
    pc_plus_4_out       = pc_q + XLEN'(IALIGN);
    misaligned_out      = mis_q;
    misaligned_addr_out = mis_addr_q;
    state_dbg_out       = state_q;
  end

endmodule

// File: tb/tb_pc_gen_seq.sv
// Bench for pc_gen_seq: directed redirect scenarios on an IALIGN=4 instance with a fetch-stream
// scoreboard, plus a short IALIGN=2 instance booting from a non-zero address.
module tb_pc_gen_seq;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: IALIGN=4, boot at 0
  logic        rst = 1'b1, stall = 1'b0, br = 1'b0, trap = 1'b0, mret = 1'b0, ready = 1'b1;
  logic [31:0] br_tgt = '0, trap_vec = '0, epc = '0;
  logic        valid, mis;
  logic [31:0] iaddr, pc, pc4, mis_addr;
  logic [1:0]  st;

  // instance b: IALIGN=2, boot at 0x1000
  logic        b_rst = 1'b1, b_br = 1'b0, b_ready = 1'b1;
  logic [31:0] b_br_tgt = '0;
  logic        b_valid, b_mis;
  logic [31:0] b_iaddr, b_pc, b_pc4, b_mis_addr;
  logic [1:0]  b_st;

  pc_gen_seq #(.XLEN(32), .BOOT_ADDR(32'h0), .IALIGN(4)) u_dut_a (
    .clk_in(clk), .rst_in(rst), .stall_in(stall),
    .branch_take_in(br), .branch_target_in(br_tgt),
    .trap_take_in(trap), .trap_vector_in(trap_vec),
    .mret_in(mret), .epc_in(epc), .ifetch_ready_in(ready),
    .ifetch_valid_out(valid), .iaddr_out(iaddr), .pc_out(pc), .pc_plus_4_out(pc4),
    .misaligned_out(mis), .misaligned_addr_out(mis_addr), .state_dbg_out(st)
  );

  pc_gen_seq #(.XLEN(32), .BOOT_ADDR(32'h1000), .IALIGN(2)) u_dut_b (
    .clk_in(clk), .rst_in(b_rst), .stall_in(1'b0),
    .branch_take_in(b_br), .branch_target_in(b_br_tgt),
    .trap_take_in(1'b0), .trap_vector_in(32'h0),
    .mret_in(1'b0), .epc_in(32'h0), .ifetch_ready_in(b_ready),
    .ifetch_valid_out(b_valid), .iaddr_out(b_iaddr), .pc_out(b_pc), .pc_plus_4_out(b_pc4),
    .misaligned_out(b_mis), .misaligned_addr_out(b_mis_addr), .state_dbg_out(b_st)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // push the address expected to fire this cycle, then advance to just past the next edge
  task automatic step(input bit f, input logic [31:0] a);
    if (f) exp_q.push_back(a);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every handshake on instance a must match the next expected fetch, in this cycle
  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_fire", iaddr, 32'hDEAD_BEEF);
      else chk("fetch_addr", iaddr, exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
      chk("missing_fire", {31'b0, valid & ready}, 32'h1);
      exp_q.delete();
    end
  end

  initial begin
    // reset
    step(0, 0);
    step(0, 0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mis", {31'b0, mis}, 32'h0);
    chk("rst_mis_addr", mis_addr, 32'h0);
    chk("rst_state", {30'b0, st}, {30'b0, ST_BOOT});

    // 1: boot cycle then sequential fetches
    rst = 1'b0;
    #1 chk("boot_valid", {31'b0, valid}, 32'h0);
    step(0, 0);
    chk("run_state", {30'b0, st}, {30'b0, ST_RUN});
    chk("seq0", iaddr, 32'h0);
    step(1, 32'h0);
    chk("seq4", iaddr, 32'h4);
    step(1, 32'h4);
    chk("seq8", iaddr, 32'h8);

    // 2: branch with ready
    br = 1'b1; br_tgt = 32'h100;
    step(1, 32'h8);
    br = 1'b0;
    chk("br_iaddr", iaddr, 32'h100);
    chk("br_pc4", pc4, 32'h104);

    // 3a: branch under back-pressure, stall cannot retract, trap replaces the pending target
    ready = 1'b0; br = 1'b1; br_tgt = 32'h200;
    step(0, 0);
    br = 1'b0; stall = 1'b1;
    chk("wait_state", {30'b0, st}, {30'b0, ST_WAIT});
    chk("wait_iaddr0", iaddr, 32'h100);
    step(0, 0);
    stall = 1'b0;
    chk("wait_stall_valid", {31'b0, valid}, 32'h1);
    chk("wait_iaddr1", iaddr, 32'h100);
    trap = 1'b1; trap_vec = 32'h80;
    step(0, 0);
    trap = 1'b0;
    chk("wait_iaddr2", iaddr, 32'h100);
    ready = 1'b1;
    step(1, 32'h100);
    chk("wait_trap_iaddr", iaddr, 32'h80);
    chk("wait_exit_state", {30'b0, st}, {30'b0, ST_RUN});

    // 3b: pending branch survives a dropped mret
    ready = 1'b0; br = 1'b1; br_tgt = 32'h200;
    step(0, 0);
    br = 1'b0; mret = 1'b1; epc = 32'h40;
    chk("wait2_iaddr", iaddr, 32'h80);
    step(0, 0);
    mret = 1'b0; ready = 1'b1;
    step(1, 32'h80);
    chk("wait_br_iaddr", iaddr, 32'h200);

    // 4: trap beats mret beats branch
    trap = 1'b1; trap_vec = 32'h80; mret = 1'b1; epc = 32'h40; br = 1'b1; br_tgt = 32'h100;
    step(1, 32'h200);
    trap = 1'b0; mret = 1'b0; br = 1'b0;
    chk("prio_iaddr", iaddr, 32'h80);

    // 5: misaligned branch rejected
    br = 1'b1; br_tgt = 32'h102;
    step(1, 32'h80);
    br = 1'b0;
    chk("mis_pulse", {31'b0, mis}, 32'h1);
    chk("mis_addr", mis_addr, 32'h102);
    chk("mis_pc_held", pc, 32'h80);
    step(1, 32'h80);
    chk("mis_pulse_end", {31'b0, mis}, 32'h0);
    chk("mis_addr_held", mis_addr, 32'h102);
    chk("mis_next", iaddr, 32'h84);

    // stall with no outstanding request, redirect taken directly while idle
    stall = 1'b1;
    #1 chk("stall_valid", {31'b0, valid}, 32'h0);
    step(0, 0);
    chk("stall_pc", pc, 32'h84);
    br = 1'b1; br_tgt = 32'h300;
    step(0, 0);
    br = 1'b0; stall = 1'b0;
    #1 chk("stall_br_valid", {31'b0, valid}, 32'h1);
    chk("stall_br_iaddr", iaddr, 32'h300);
    step(1, 32'h300);
    chk("stall_seq", iaddr, 32'h304);

    // 6: wrap
    br = 1'b1; br_tgt = 32'hFFFF_FFFC;
    step(1, 32'h304);
    br = 1'b0;
    chk("wrap_pre", iaddr, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    step(1, 32'hFFFF_FFFC);
    chk("wrap_iaddr", iaddr, 32'h0);

    // trap vector with bit 1 set is realigned, not rejected
    trap = 1'b1; trap_vec = 32'h86;
    step(1, 32'h0);
    trap = 1'b0;
    chk("trap_align_iaddr", iaddr, 32'h84);
    chk("trap_align_mis", {31'b0, mis}, 32'h0);

    // reset in the middle of a pending redirect
    ready = 1'b0; br = 1'b1; br_tgt = 32'h500;
    step(0, 0);
    br = 1'b0;
    chk("rw_state", {30'b0, st}, {30'b0, ST_WAIT});
    rst = 1'b1;
    step(0, 0);
    chk("rw_rst_state", {30'b0, st}, {30'b0, ST_BOOT});
    chk("rw_rst_pc", pc, 32'h0);
    chk("rw_rst_valid", {31'b0, valid}, 32'h0);
    chk("rw_rst_mis_addr", mis_addr, 32'h0);
    rst = 1'b0; ready = 1'b1;
    step(0, 0);
    chk("rw_boot_iaddr", iaddr, 32'h0);
    step(1, 32'h0);
    chk("rw_seq", iaddr, 32'h4);
    ready = 1'b0;

    // instance b: IALIGN=2
    step(0, 0);
    chk("b_rst_iaddr", b_iaddr, 32'h1000);
    chk("b_rst_valid", {31'b0, b_valid}, 32'h0);
    b_rst = 1'b0;
    step(0, 0);
    chk("b_boot_iaddr", b_iaddr, 32'h1000);
    chk("b_state", {30'b0, b_st}, {30'b0, ST_RUN});
    b_br = 1'b1; b_br_tgt = 32'h102;
    step(0, 0);
    chk("b_br_iaddr", b_iaddr, 32'h102);
    chk("b_br_mis", {31'b0, b_mis}, 32'h0);
    chk("b_br_pc4", b_pc4, 32'h104);
    b_br_tgt = 32'h107;
    step(0, 0);
    b_br = 1'b0;
    chk("b_bit0_iaddr", b_iaddr, 32'h106);
    step(0, 0);
    chk("b_seq", b_pc, 32'h108);
    chk("b_mis_addr", b_mis_addr, 32'h0);

    step(0, 0);
    chk("sb_drain", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
